// File: rtl/rgmii_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_speed_ctrl
// Purpose  : Link-speed switch sequencer for the RGMII MAC datapath. Quiesces
//            TX, holds the MAC in reset, flips the clock-mux / DDR-SDR select,
//            lets clocks settle and releases the datapath again.
// Revision : 1.0  initial release
// ============================================================================
module rgmii_speed_ctrl #(
  parameter int         DRAIN_TIMEOUT = 1024,
  parameter int         GATE_CYCLES   = 16,
  parameter int         SETTLE_CYCLES = 64,
  parameter logic [1:0] RESET_SPEED   = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_speed,
  output logic       req_ready,
  input  logic       tx_idle,
  output logic       tx_pause,
  output logic       mac_rst,
  output logic       clk_sel,
  output logic       mii_sel,
  output logic [1:0] speed,
  output logic       done,
  output logic       err,
  output logic       drain_to
);

  // Counter is shared by DRAIN, GATE and SETTLE, so it is sized for the longest.
  localparam int c_max_ab  = (DRAIN_TIMEOUT > GATE_CYCLES) ? DRAIN_TIMEOUT : GATE_CYCLES;
  localparam int c_max_cyc = (c_max_ab > SETTLE_CYCLES) ? c_max_ab : SETTLE_CYCLES;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

  localparam logic [c_cnt_w-1:0] c_drain_last  = c_cnt_w'(DRAIN_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_gate_last   = c_cnt_w'(GATE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max     = {c_cnt_w{1'b1}};

  localparam logic [1:0] c_speed_1g   = 2'b10;
  localparam logic [1:0] c_speed_bad  = 2'b11;
  localparam logic       c_clk_sel_rs = (RESET_SPEED == c_speed_1g);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_GATE    = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [1:0]         req_q, req_d;
  logic [1:0]         speed_q, speed_d;
  logic               clk_sel_q, clk_sel_d;
  logic               mii_sel_q, mii_sel_d;
  logic               mac_rst_q, mac_rst_d;
  logic               tx_pause_q, tx_pause_d;
  logic               req_ready_q, req_ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               drain_to_q, drain_to_d;
  logic               w_accept;

  assign w_accept = req_valid && req_ready_q;

  // Next-state, counter and output decode. Outputs are derived from the next
  // state so that each registered output lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    speed_d    = speed_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    drain_to_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (req_speed == c_speed_bad) begin
            err_d = 1'b1;
          end else if (req_speed == speed_q) begin
            done_d = 1'b1;
          end else begin
            req_d   = req_speed;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (tx_idle || (cnt_q == c_drain_last)) state_d = ST_GATE;
      end
      ST_GATE: begin
        if (cnt_q == c_gate_last) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        // Select lines move here, landing in the first SETTLE cycle under reset.
        speed_d = req_q;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == c_settle_last) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear on state entry, otherwise count up and saturate.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_cnt_max) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end

    // The timeout pulse must be visible during the last DRAIN cycle itself,
    // so it is raised as the counter steps onto its final value.
    drain_to_d  = (state_d == ST_DRAIN) && (cnt_d == c_drain_last);
    done_d      = done_d || (state_d == ST_RELEASE);
    req_ready_d = (state_d == ST_IDLE);
    tx_pause_d  = (state_d != ST_IDLE) && (state_d != ST_RELEASE);
    mac_rst_d   = (state_d == ST_GATE) || (state_d == ST_SWITCH) ||
                  (state_d == ST_SETTLE);
    clk_sel_d   = (speed_d == c_speed_1g);
    mii_sel_d   = (speed_d != c_speed_1g);
  end

  // State and output registers; reset lands in SETTLE to run the power-up hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      req_q       <= RESET_SPEED;
      speed_q     <= RESET_SPEED;
      clk_sel_q   <= c_clk_sel_rs;
      mii_sel_q   <= ~c_clk_sel_rs;
      mac_rst_q   <= 1'b1;
      tx_pause_q  <= 1'b1;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drain_to_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      speed_q     <= speed_d;
      clk_sel_q   <= clk_sel_d;
      mii_sel_q   <= mii_sel_d;
      mac_rst_q   <= mac_rst_d;
      tx_pause_q  <= tx_pause_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      drain_to_q  <= drain_to_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_pause  = tx_pause_q;
  assign mac_rst   = mac_rst_q;
  assign clk_sel   = clk_sel_q;
  assign mii_sel   = mii_sel_q;
  assign speed     = speed_q;
  assign done      = done_q;
  assign err       = err_q;
  assign drain_to  = drain_to_q;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgmii_speed_ctrl
// Purpose  : Self-checking bench for rgmii_speed_ctrl. Expected outputs come
//            from a transaction-level timeline computed per request.
// Revision : 1.0  initial release
// ============================================================================
module tb_rgmii_speed_ctrl;

  localparam int         TO = 1024;
  localparam int         G  = 16;
  localparam int         S  = 64;
  localparam logic [1:0] RS = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_speed = 2'b00;
  logic       tx_idle = 1'b1;
  logic       req_ready, tx_pause, mac_rst, clk_sel, mii_sel;
  logic [1:0] speed;
  logic       done, err, drain_to;
  logic [9:0] obs;

  int         n_checks = 0;
  int         n_errs   = 0;
  int         n_stuck  = 0;
  logic [1:0] cur = RS;

  always #5 clk = ~clk;

  rgmii_speed_ctrl #(
    .DRAIN_TIMEOUT(TO),
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .RESET_SPEED  (RS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_speed(req_speed),
    .req_ready(req_ready),
    .tx_idle  (tx_idle),
    .tx_pause (tx_pause),
    .mac_rst  (mac_rst),
    .clk_sel  (clk_sel),
    .mii_sel  (mii_sel),
    .speed    (speed),
    .done     (done),
    .err      (err),
    .drain_to (drain_to)
  );

  assign obs = {req_ready, tx_pause, mac_rst, clk_sel, mii_sel, speed, done, err, drain_to};

  // Expected output vector from the externally visible rules.
  function automatic logic [9:0] mk(input logic rdy, input logic pause, input logic mrst,
                                    input logic [1:0] spd, input logic dn,
                                    input logic er, input logic dto);
    mk = {rdy, pause, mrst, (spd == 2'b10), (spd != 2'b10), spd, dn, er, dto};
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b expected %b (rdy,pause,mrst,csel,msel,spd[2],done,err,dto) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reset held a few cycles, then the power-up hold of S cycles and RELEASE.
  task automatic powerup();
    repeat (3) begin
      @(negedge clk);
      chk("in_reset", obs, mk(1'b0, 1'b1, 1'b1, RS, 1'b0, 1'b0, 1'b0));
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    for (int j = 1; j <= S + 1; j++) begin
      @(negedge clk);
      if (j <= S - 1)
        chk($sformatf("pwrup_settle j=%0d", j), obs, mk(1'b0, 1'b1, 1'b1, RS, 1'b0, 1'b0, 1'b0));
      else if (j == S)
        chk("pwrup_release", obs, mk(1'b0, 1'b0, 1'b0, RS, 1'b1, 1'b0, 1'b0));
      else
        chk("pwrup_idle", obs, mk(1'b1, 1'b0, 1'b0, RS, 1'b0, 1'b0, 1'b0));
    end
    cur = RS;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle", obs, mk(1'b1, 1'b0, 1'b0, cur, 1'b0, 1'b0, 1'b0));
      req_valid = 1'b0;
      tx_idle   = 1'($urandom_range(0, 1));
    end
  endtask

  // Invalid or same-speed request: a single response pulse, no sequence.
  task automatic req_simple(input logic [1:0] rs);
    req_valid = 1'b1;
    req_speed = rs;
    @(negedge clk);
    chk((rs == 2'b11) ? "req_invalid" : "req_same", obs,
        mk(1'b1, 1'b0, 1'b0, cur, (rs == cur), (rs == 2'b11), 1'b0));
    req_valid = 1'b0;
  endtask

  // Speed change accepted this cycle (T). tx_idle low for d cycles after T.
  // hold keeps req_valid asserted throughout; stop_k > 0 aborts at that offset.
  task automatic req_change(input logic [1:0] nw, input int d, input bit hold, input int stop_k);
    int         dd;
    bit         tmo;
    int         last;
    logic [1:0] old;
    logic [9:0] exp;
    old       = cur;
    tmo       = (d >= TO);
    dd        = tmo ? TO : d + 1;
    last      = dd + G + S + 3;
    req_valid = 1'b1;
    req_speed = nw;
    tx_idle   = 1'($urandom_range(0, 1));
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k <= dd)
        exp = mk(1'b0, 1'b1, 1'b0, old, 1'b0, 1'b0, (tmo && k == dd));
      else if (k <= dd + G + 1)
        exp = mk(1'b0, 1'b1, 1'b1, old, 1'b0, 1'b0, 1'b0);
      else if (k <= dd + G + S + 1)
        exp = mk(1'b0, 1'b1, 1'b1, nw, 1'b0, 1'b0, 1'b0);
      else if (k == dd + G + S + 2)
        exp = mk(1'b0, 1'b0, 1'b0, nw, 1'b1, 1'b0, 1'b0);
      else
        exp = mk(1'b1, 1'b0, 1'b0, nw, 1'b0, 1'b0, 1'b0);
      chk($sformatf("chg k=%0d", k), obs, exp);
      req_valid = hold;
      tx_idle   = (k <= d) ? 1'b0 : 1'b1;
      if (k == stop_k) return;
    end
    cur = nw;
    if (hold) begin
      @(negedge clk);
      chk("held_req", obs, mk(1'b1, 1'b0, 1'b0, nw, 1'b1, 1'b0, 1'b0));
      req_valid = 1'b0;
    end
  endtask

  initial begin
    int         sel;
    int         gap;
    int         d;
    bit         hold;
    logic [1:0] nw;

    powerup();

    // Directed cases.
    req_change(2'b01, 0, 1'b0, 0);
    req_change(2'b10, 5, 1'b0, 0);
    req_change(2'b00, TO + 10, 1'b0, 0);
    req_simple(2'b11);
    req_simple(cur);
    idle_cycles(2);

    // Randomized request mix.
    for (int i = 0; i < 30; i++) begin
      gap = int'($urandom_range(0, 3));
      idle_cycles(gap);
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        req_simple(2'b11);
      end else if (sel < 4) begin
        req_simple(cur);
      end else begin
        nw = 2'((int'(cur) + int'($urandom_range(1, 2))) % 3);
        if (sel == 9 && n_stuck < 1) begin
          d = TO + 3;
          n_stuck++;
        end else begin
          d = int'($urandom_range(0, 8));
        end
        hold = ($urandom_range(0, 3) == 0);
        req_change(nw, d, hold, 0);
      end
    end

    // Asynchronous reset in SETTLE after a switch to 10M.
    if (cur == 2'b00) req_change(2'b01, 0, 1'b0, 0);
    req_change(2'b00, 0, 1'b0, G + 7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", obs, mk(1'b0, 1'b1, 1'b1, RS, 1'b0, 1'b0, 1'b0));
    powerup();
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    n_errs++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rgmii_speed_ctrl.md
# rgmii_speed_ctrl

Link-speed switch sequencer for the RGMII MAC datapath. It accepts a speed-change request from the PHY status/MDIO logic and drives the clock-mux select (BUFGMUX `S`) and the DDR/SDR mode select of the IDDR/ODDR path. While it does so it quiesces the transmitter and holds the MAC datapath in reset, so no frame straddles a clock switch. It is the only writer of the speed-related controls in the MAC wrapper.

## Interface
Parameters:
- `DRAIN_TIMEOUT`, 1024: maximum cycles spent waiting for `tx_idle` before forcing the switch.
- `GATE_CYCLES`, 16: cycles `mac_rst` is held before the mux select changes.
- `SETTLE_CYCLES`, 64: cycles `mac_rst` is held after the mux select changes.
- `RESET_SPEED`, 2'b10: speed after reset (00 = 10M, 01 = 100M, 10 = 1000M).

Ports:
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  speed-change request valid.
- `req_speed`  in  2  requested speed; 2'b11 is invalid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `tx_idle`  in  1  MAC TX has no frame in flight.
- `tx_pause`  out  1  MAC must not start a new frame.
- `mac_rst`  out  1  synchronous reset to the MAC datapath.
- `clk_sel`  out  1  BUFGMUX select; 1 = 125 MHz TX clock (gigabit).
- `mii_sel`  out  1  1 = SDR/MII nibble mode (10/100); 0 = DDR mode.
- `speed`  out  2  currently applied speed.
- `done`  out  1  one-cycle pulse: request completed.
- `err`  out  1  one-cycle pulse: invalid request rejected.
- `drain_to`  out  1  one-cycle pulse: drain timed out.

## Operation
- All outputs are registered. `done`, `err` and `drain_to` are one-cycle pulses.
- States: IDLE, DRAIN, GATE, SWITCH, SETTLE, RELEASE.
- Decode of `speed`: `clk_sel = (speed == 2'b10)`, `mii_sel = (speed != 2'b10)`.
- Reset values while `rst` is high:
  - `speed = RESET_SPEED`, with `clk_sel`/`mii_sel` decoded from it.
  - `mac_rst = 1`, `tx_pause = 1`.
  - `req_ready`, `done`, `err`, `drain_to` = 0.
  - State = SETTLE with its counter cleared. The first power-up therefore holds `mac_rst` for `SETTLE_CYCLES`, then passes through RELEASE to IDLE. RELEASE raises `done` on this path as well.
- IDLE:
  - `req_ready = 1`, `tx_pause = 0`, `mac_rst = 0`.
  - When a request is accepted, the response depends on `req_speed`:
    - 2'b11: `err` pulses the next cycle; remain in IDLE; nothing else changes.
    - Equal to `speed`: `done` pulses the next cycle; remain in IDLE; no sequence runs.
    - Otherwise: latch `req_speed`, go to DRAIN.
- DRAIN:
  - `tx_pause = 1`, `mac_rst = 0`; a counter runs.
  - Go to GATE when `tx_idle` is sampled 1.
  - Otherwise, in the cycle the counter reaches `DRAIN_TIMEOUT-1`, go to GATE and pulse `drain_to`.
- GATE: `tx_pause = 1`, `mac_rst = 1` for `GATE_CYCLES` cycles, then go to SWITCH.
- SWITCH (1 cycle): `speed` loads the latched request; the new `clk_sel`/`mii_sel` are visible from the first SETTLE cycle.
- SETTLE: `mac_rst = 1`, `tx_pause = 1` for `SETTLE_CYCLES` cycles, then go to RELEASE.
- RELEASE (1 cycle): `mac_rst = 0`, `tx_pause = 0`, `done = 1`; then go to IDLE.
- `req_ready = 0` in every state except IDLE. A request held on `req_valid` during a sequence waits; it is not dropped.
- `clk_sel`/`mii_sel` change only on the SWITCH-to-SETTLE edge, and only while `mac_rst = 1`.
- Counters are `$clog2(max(DRAIN_TIMEOUT, SETTLE_CYCLES, GATE_CYCLES)+1)` bits wide. Each counter clears on state entry and never wraps.
- Reset mid-sequence: all outputs return to reset values immediately and the latched request is discarded.

## Timing
- Request accepted at cycle T with `tx_idle = 1`, G = `GATE_CYCLES`, S = `SETTLE_CYCLES`:

  | Cycles | State | Outputs |
  |---|---|---|
  | T+1 | DRAIN | `tx_pause` 1 |
  | T+2 … T+1+G | GATE | `mac_rst` 1 |
  | T+2+G | SWITCH | |
  | T+3+G … T+2+G+S | SETTLE | new `speed` / `clk_sel` / `mii_sel` |
  | T+3+G+S | RELEASE | `done` 1, `mac_rst` 0, `tx_pause` 0 |
  | T+4+G+S | IDLE | `req_ready` 1 |

- With `tx_idle` stuck at 0, DRAIN lasts exactly `DRAIN_TIMEOUT` cycles, and `drain_to` pulses in its last cycle.
- Same-speed or invalid request accepted at cycle T: `done` or `err` is high at T+1, and `req_ready` stays 1.
- No back-to-back acceptance across a switch: there is at least one RELEASE cycle between two sequences.

## Test plan
- Power-up, defaults (G = 16, S = 64):
  - During `rst`: `speed = 10`, `clk_sel = 1`, `mii_sel = 0`, `mac_rst = 1`.
  - `mac_rst` stays 1 for 64 cycles after `rst` falls.
  - `done` pulses once, then `req_ready = 1`.
- Request 1000M → 100M with `tx_idle = 1` at T:
  - `tx_pause` rises at T+1 and `mac_rst` at T+2.
  - `clk_sel` goes 0 and `mii_sel` goes 1 at T+19.
  - `done` pulses at T+83; `req_ready` is 1 at T+84.
- `tx_idle` held low for 5 cycles after acceptance at T, then high: GATE is entered at T+7; no `drain_to`.
- `tx_idle` stuck low with `DRAIN_TIMEOUT` = 1024: `drain_to` pulses at T+1024, GATE is entered at T+1025, and the switch completes normally.
- Degenerate requests:
  - `req_speed = 11`: `err` pulses at T+1; `speed` is unchanged.
  - `req_speed` equal to the current `speed`: `done` pulses at T+1; `mac_rst` never rises.
- `rst` asserted asynchronously in SETTLE after a switch to 10M:
  - `speed` returns to 10 at once; `mac_rst` stays 1.
  - The power-up SETTLE/RELEASE sequence then repeats.
